register_file_sb: RTL and testbench

//  Parametrised, scoreboarded register file for the ssprocessor datapath:
//  2**AW registers of W bits, two async read ports, one sync write port.

---
 rtl/register_file_sb.sv | 93 +++++++++
 tb/tb_register_file_sb.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// Scoreboarded register file: 2**AW x W registers, two async read ports, one sync write port,
// per-register busy bits with issue/writeback. Define RF_BYPASS_EN for write-to-read forwarding.
module register_file_sb #(
   parameter int unsigned W  = 8,
   parameter int unsigned AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  din1,
   input  logic [AW-1:0] Rd,
   input  logic          wrt,
   input  logic [AW-1:0] Rn,
   input  logic [AW-1:0] Rm,
   output logic [W-1:0]  dout1,
   output logic [W-1:0]  dout2,
   output logic          rdy1,
   output logic          rdy2,
   input  logic          iss,
   input  logic [AW-1:0] Ri,
   output logic          iss_ok,
   output logic [AW:0]   busy_cnt
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [W-1:0]     regs_q [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;
   logic [AW:0]      busy_cnt_q;
   logic [AW:0]      busy_cnt_d;
   logic             wb_clr;

   // Issue acceptance always looks at registered busy state, even with forwarding enabled.
   assign iss_ok = iss & ~busy_q[Ri];

   // A writeback only lowers the count if it actually frees a busy entry that the
   // same-cycle issue is not re-claiming.
   assign wb_clr = wrt & busy_q[Rd] & ~(iss_ok & (Ri == Rd));

   always_comb begin
      busy_d = busy_q;
      if (wrt) begin
         busy_d[Rd] = 1'b0;
      end
      if (iss_ok) begin
         busy_d[Ri] = 1'b1;
      end
      busy_cnt_d = busy_cnt_q + {{AW{1'b0}}, iss_ok} - {{AW{1'b0}}, wb_clr};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         if (wrt) begin
            regs_q[Rd] <= din1;
         end
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt = busy_cnt_q;

`ifdef RF_BYPASS_EN
   always_comb begin
      dout1 = regs_q[Rn];
      rdy1  = ~busy_q[Rn];
      dout2 = regs_q[Rm];
      rdy2  = ~busy_q[Rm];
      if (wrt && (Rd == Rn)) begin
         dout1 = din1;
         rdy1  = 1'b1;
      end
      if (wrt && (Rd == Rm)) begin
         dout2 = din1;
         rdy2  = 1'b1;
      end
   end
`else
   always_comb begin
      dout1 = regs_q[Rn];
      rdy1  = ~busy_q[Rn];
      dout2 = regs_q[Rm];
      rdy2  = ~busy_q[Rm];
   end
`endif

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: expectations queued per cycle from a reference model,
// a monitor pops and compares at the falling edge.
module tb_register_file_sb;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] din1 = '0;
   logic [3:0] Rd = '0;
   logic       wrt = 1'b0;
   logic [3:0] Rn = '0;
   logic [3:0] Rm = '0;
   logic [7:0] dout1;
   logic [7:0] dout2;
   logic       rdy1;
   logic       rdy2;
   logic       iss = 1'b0;
   logic [3:0] Ri = '0;
   logic       iss_ok;
   logic [4:0] busy_cnt;

   register_file_sb #(.W(8), .AW(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .din1     (din1),
      .Rd       (Rd),
      .wrt      (wrt),
      .Rn       (Rn),
      .Rm       (Rm),
      .dout1    (dout1),
      .dout2    (dout2),
      .rdy1     (rdy1),
      .rdy2     (rdy2),
      .iss      (iss),
      .Ri       (Ri),
      .iss_ok   (iss_ok),
      .busy_cnt (busy_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d1;
      logic [7:0] d2;
      logic       r1;
      logic       r2;
      logic       ok;
      logic [4:0] cnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: plain arrays of contents and pending flags.
   logic [7:0] mem [16];
   bit         pend [16];
   bit         model_valid = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [4:0] pend_count();
      int n = 0;
      for (int i = 0; i < 16; i++) if (pend[i]) n++;
      return n[4:0];
   endfunction

   // Inputs applied just after a rising edge; expectation queued; model advanced on the next edge.
   task automatic drive(input logic a_rst, input logic a_wrt, input logic [7:0] a_din,
                        input logic [3:0] a_rd, input logic [3:0] a_rn, input logic [3:0] a_rm,
                        input logic a_iss, input logic [3:0] a_ri);
      exp_t e;
      bit   accept;
      rst = a_rst; wrt = a_wrt; din1 = a_din; Rd = a_rd; Rn = a_rn; Rm = a_rm;
      iss = a_iss; Ri = a_ri;
      if (model_valid) begin
         e.d1  = mem[a_rn];
         e.r1  = !pend[a_rn];
         e.d2  = mem[a_rm];
         e.r2  = !pend[a_rm];
`ifdef RF_BYPASS_EN
         if (a_wrt && a_rd == a_rn) begin e.d1 = a_din; e.r1 = 1'b1; end
         if (a_wrt && a_rd == a_rm) begin e.d2 = a_din; e.r2 = 1'b1; end
`endif
         e.ok  = a_iss && !pend[a_ri];
         e.cnt = pend_count();
         q.push_back(e);
      end
      accept = a_iss && !pend[a_ri];
      @(posedge clk);
      if (a_rst) begin
         for (int i = 0; i < 16; i++) begin mem[i] = '0; pend[i] = 0; end
         model_valid = 1;
      end else begin
         if (a_wrt) begin mem[a_rd] = a_din; pend[a_rd] = 0; end
         if (accept) pend[a_ri] = 1;
      end
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("dout1", dout1, e.d1);
            chk("dout2", dout2, e.d2);
            chk("rdy1", rdy1, e.r1);
            chk("rdy2", rdy2, e.r2);
            chk("iss_ok", iss_ok, e.ok);
            chk("busy_cnt", busy_cnt, e.cnt);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [3:0] a, b;
      @(posedge clk); #1;
      // Reset, then sweep every address.
      drive(1, 0, 8'h00, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         a = i[3:0];
         b = 4'(15 - i);
         drive(0, 0, 8'h00, 0, a, b, 0, 0);
      end
      // Write then read on both ports.
      drive(0, 1, 8'hA5, 3, 0, 0, 0, 0);
      drive(0, 0, 8'h00, 0, 3, 3, 0, 0);
      // Issue, refused re-issue, writeback.
      drive(0, 0, 8'h00, 0, 5, 5, 1, 5);
      drive(0, 0, 8'h00, 0, 5, 5, 1, 5);
      drive(0, 1, 8'h3C, 5, 5, 3, 0, 0);
      drive(0, 0, 8'h00, 0, 5, 3, 0, 0);
      // Writeback and issue on different registers, then refused issue with writeback.
      drive(0, 0, 8'h00, 0, 7, 2, 1, 7);
      drive(0, 1, 8'h11, 7, 7, 2, 1, 2);
      drive(0, 1, 8'h22, 2, 7, 2, 1, 2);
      drive(0, 0, 8'h00, 0, 7, 2, 0, 0);
      // Accepted issue and write to the same register.
      drive(0, 1, 8'h5A, 9, 9, 9, 1, 9);
      drive(0, 0, 8'h00, 0, 9, 9, 0, 0);
      drive(0, 1, 8'h5B, 9, 9, 9, 0, 0);
      // Fill every busy bit, then reset with wrt and iss high.
      for (int i = 0; i < 16; i++) drive(0, 0, 8'h00, 0, 4, 0, 1, i[3:0]);
      drive(0, 0, 8'h00, 0, 0, 15, 1, 3);
      drive(1, 1, 8'hFF, 6, 6, 3, 1, 6);
      drive(0, 0, 8'h00, 0, 6, 3, 0, 0);
      // Busy register written while being read.
      drive(0, 0, 8'h00, 0, 4, 4, 1, 4);
      drive(0, 1, 8'h77, 4, 4, 1, 0, 0);
      drive(0, 0, 8'h00, 0, 4, 1, 0, 0);
      // Random traffic on a narrowed address range to provoke collisions.
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] rd, rn, rm, ri;
         rd = 4'($urandom_range(0, 15)) & ((n % 3 == 0) ? 4'hF : 4'h3);
         rn = 4'($urandom_range(0, 15)) & ((n % 3 == 0) ? 4'hF : 4'h3);
         rm = 4'($urandom_range(0, 15)) & ((n % 3 == 0) ? 4'hF : 4'h3);
         ri = 4'($urandom_range(0, 15)) & ((n % 3 == 0) ? 4'hF : 4'h3);
         drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
               8'($urandom), rd, rn, rm, ($urandom_range(0, 1) == 1), ri);
      end
      drive(0, 0, 8'h00, 0, 0, 0, 0, 0);
      @(negedge clk); #1;
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
